// File: rtl/sdio_reg_arbiter.sv
// Round-robin arbiter sharing one SDIO register-access port between NREQ requesters.
// Latches the winner's command, holds the strobe until ready or timeout, then enforces an idle gap.
module sdio_reg_arbiter #(
  parameter int AW        = 8,
  parameter int NREQ      = 2,
  parameter int GAP_CYC   = 2,
  parameter int SLOW_CYC  = 2000,
  parameter int ABORT_CYC = 4095
) (
  input  logic               clk_2,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_rd,
  input  logic [NREQ-1:0]    req_wr,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_writedata,
  output logic [NREQ-1:0]    req_ack,
  output logic [31:0]        req_readdata,
  output logic               req_err,
  output logic               busy,
  output logic               sdio_rd,
  output logic               sdio_wr,
  output logic [AW-1:0]      sdio_addr,
  output logic [31:0]        sdio_writedata,
  input  logic               sdio_ready,
  input  logic [31:0]        sdio_readdata
);

  localparam int          IW     = (NREQ > 2) ? 2 : 1;
  localparam logic [11:0] SLOW_L  = 12'(SLOW_CYC);
  localparam logic [11:0] ABORT_L = 12'(ABORT_CYC);
  localparam logic [7:0]  GAP_L   = 8'(GAP_CYC);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE, GAP} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic [IW-1:0]   last, last_nxt;
  logic [11:0]     cnt, cnt_nxt;
  logic [7:0]      gap_cnt, gap_cnt_nxt;
  logic [AW-1:0]   addr_nxt;
  logic [31:0]     wdata_nxt;
  logic [31:0]     rdata_nxt;
  logic            err_nxt;
  logic            rd_nxt, wr_nxt, busy_nxt;
  logic [NREQ-1:0] ack_nxt;
  logic [NREQ-1:0] pending;
  logic [IW-1:0]   pick;

  // First pending index after the previous winner, wrapping modulo NREQ.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] p, input logic [IW-1:0] from);
    logic [IW-1:0] sel;
    logic          found;
    int            j;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(from) + k) % NREQ;
      if (!found && p[j]) begin
        sel   = IW'(j);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign pending = req_rd | req_wr;
  assign pick    = rr_pick(pending, last);

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    last_nxt    = last;
    cnt_nxt     = cnt;
    gap_cnt_nxt = gap_cnt;
    addr_nxt    = sdio_addr;
    wdata_nxt   = sdio_writedata;
    rdata_nxt   = req_readdata;
    err_nxt     = req_err;
    rd_nxt      = 1'b0;
    wr_nxt      = 1'b0;
    ack_nxt     = '0;
    unique case (state)
      IDLE: begin
        if (|pending) begin
          idx_nxt   = pick;
          addr_nxt  = req_addr[int'(pick)*AW +: AW];
          wdata_nxt = req_writedata[int'(pick)*32 +: 32];
          wr_nxt    = req_wr[pick];
          rd_nxt    = ~req_wr[pick];
          cnt_nxt   = '0;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        rd_nxt = sdio_rd;
        wr_nxt = sdio_wr;
        // A ready on the final counted cycle still wins over the forced abort.
        if (sdio_ready) begin
          rdata_nxt    = sdio_readdata;
          err_nxt      = (cnt >= SLOW_L);
          rd_nxt       = 1'b0;
          wr_nxt       = 1'b0;
          ack_nxt[idx] = 1'b1;
          state_nxt    = DONE;
        end else if (cnt >= ABORT_L) begin
          rdata_nxt    = 32'hDEAD_0000 | 32'(idx);
          err_nxt      = 1'b1;
          rd_nxt       = 1'b0;
          wr_nxt       = 1'b0;
          ack_nxt[idx] = 1'b1;
          state_nxt    = DONE;
        end else begin
          cnt_nxt = cnt + 12'd1;
        end
      end
      DONE: begin
        last_nxt    = idx;
        gap_cnt_nxt = 8'd1;
        state_nxt   = (GAP_L <= 8'd1) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt + 8'd1 >= GAP_L) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // Every output is a flop loaded from the next-state logic, so nothing is combinational from inputs.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      last           <= IW'(NREQ - 1);
      cnt            <= '0;
      gap_cnt        <= '0;
      sdio_rd        <= 1'b0;
      sdio_wr        <= 1'b0;
      sdio_addr      <= '0;
      sdio_writedata <= '0;
      req_ack        <= '0;
      req_readdata   <= '0;
      req_err        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      last           <= last_nxt;
      cnt            <= cnt_nxt;
      gap_cnt        <= gap_cnt_nxt;
      sdio_rd        <= rd_nxt;
      sdio_wr        <= wr_nxt;
      sdio_addr      <= addr_nxt;
      sdio_writedata <= wdata_nxt;
      req_ack        <= ack_nxt;
      req_readdata   <= rdata_nxt;
      req_err        <= err_nxt;
      busy           <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_sdio_reg_arbiter.sv
// Bench for sdio_reg_arbiter: requesters and an SDIO master model driven from queued transactions;
// expected acks are derived from round-robin order and ready delays and checked by a separate monitor.
module tb_sdio_reg_arbiter;

  localparam int AW        = 8;
  localparam int NREQ      = 2;
  localparam int GAP_CYC   = 2;
  localparam int SLOW_CYC  = 2000;
  localparam int ABORT_CYC = 4095;

  logic               clk_2 = 1'b0;
  logic               rst_n = 1'b1;
  logic [NREQ-1:0]    req_rd = '0;
  logic [NREQ-1:0]    req_wr = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*32-1:0] req_writedata = '0;
  logic [NREQ-1:0]    req_ack;
  logic [31:0]        req_readdata;
  logic               req_err;
  logic               busy;
  logic               sdio_rd;
  logic               sdio_wr;
  logic [AW-1:0]      sdio_addr;
  logic [31:0]        sdio_writedata;
  logic               sdio_ready = 1'b0;
  logic [31:0]        sdio_readdata = '0;

  sdio_reg_arbiter #(
    .AW(AW), .NREQ(NREQ), .GAP_CYC(GAP_CYC), .SLOW_CYC(SLOW_CYC), .ABORT_CYC(ABORT_CYC)
  ) dut (
    .clk_2(clk_2), .rst_n(rst_n),
    .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_writedata(req_writedata),
    .req_ack(req_ack), .req_readdata(req_readdata), .req_err(req_err), .busy(busy),
    .sdio_rd(sdio_rd), .sdio_wr(sdio_wr), .sdio_addr(sdio_addr), .sdio_writedata(sdio_writedata),
    .sdio_ready(sdio_ready), .sdio_readdata(sdio_readdata)
  );

  always #5 clk_2 = ~clk_2;

  // op: 0 read, 1 write, 2 read+write; delay: strobe-high cycles before ready is seen, 0 = never
  typedef struct {
    int            port;
    int            op;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    int            delay;
    logic [31:0]   rdata;
    bit            drop;
  } tx_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  tx_t  port_q[NREQ][$];
  tx_t  resp_q[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   model_last = NREQ - 1;
  bit   skip_len = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic failNow(input string name);
    n_checks++;
    $display("[TB] FAIL %s: event occurred, expected none", name);
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] p, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (last + k) % NREQ;
      if (p[j]) return j;
    end
    return 0;
  endfunction

  function automatic bit is_abort(input int d);
    return (d == 0) || (d - 1 > ABORT_CYC);
  endfunction

  function automatic int exp_len(input int d);
    return is_abort(d) ? ABORT_CYC + 1 : d;
  endfunction

  task automatic addTx(input int port, input int op, input logic [AW-1:0] addr, input logic [31:0] wdata,
                       input int delay, input logic [31:0] rdata, input bit drop);
    tx_t t;
    t.port = port; t.op = op; t.addr = addr; t.wdata = wdata;
    t.delay = delay; t.rdata = rdata; t.drop = drop;
    port_q[port].push_back(t);
  endtask

  task automatic loadPort(input int i);
    if (port_q[i].size() > 0) begin
      req_rd[i] = (port_q[i][0].op != 1);
      req_wr[i] = (port_q[i][0].op != 0);
      req_addr[i*AW +: AW] = port_q[i][0].addr;
      req_writedata[i*32 +: 32] = port_q[i][0].wdata;
    end else begin
      req_rd[i] = 1'b0;
      req_wr[i] = 1'b0;
    end
  endtask

  function automatic bit anyPending();
    for (int i = 0; i < NREQ; i++) if (port_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Predicts grant order from the queued work, then drives every port, reloading each after its ack.
  task automatic applyStimulus();
    int              left[NREQ];
    int              total = 0;
    int              budget = 100;
    int              g;
    int              last_m = model_last;
    logic [NREQ-1:0] pend;
    tx_t             t;
    exp_t            e;
    for (int i = 0; i < NREQ; i++) begin
      left[i] = port_q[i].size();
      total += left[i];
    end
    for (int n = 0; n < total; n++) begin
      for (int i = 0; i < NREQ; i++) pend[i] = (left[i] > 0);
      g = rr_pick(pend, last_m);
      t = port_q[g][port_q[g].size() - left[g]];
      left[g]--;
      last_m = g;
      resp_q.push_back(t);
      e.port  = g;
      e.rdata = is_abort(t.delay) ? (32'hDEAD_0000 | 32'(g)) : t.rdata;
      e.err   = is_abort(t.delay) || (t.delay - 1 >= SLOW_CYC);
      exp_q.push_back(e);
      budget += exp_len(t.delay) + GAP_CYC + 8;
    end
    model_last = last_m;
    @(negedge clk_2);
    for (int i = 0; i < NREQ; i++) loadPort(i);
    while (anyPending() && budget > 0) begin
      @(negedge clk_2);
      budget--;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ack[i] && port_q[i].size() > 0) begin
          void'(port_q[i].pop_front());
          loadPort(i);
        end else if (port_q[i].size() > 0 && port_q[i][0].drop && (sdio_rd || sdio_wr)) begin
          req_rd[i] = 1'b0;
          req_wr[i] = 1'b0;
          req_addr[i*AW +: AW] = ~port_q[i][0].addr;
          req_writedata[i*32 +: 32] = ~port_q[i][0].wdata;
        end
      end
    end
    if (budget <= 0) begin
      failNow("phase_timeout");
      for (int i = 0; i < NREQ; i++) port_q[i].delete();
      resp_q.delete();
      exp_q.delete();
      req_rd = '0;
      req_wr = '0;
    end
    repeat (GAP_CYC + 2) @(negedge clk_2);
    checkOutput("exp_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic resetMidIssue();
    tx_t t;
    int  w = 0;
    t.port = 0; t.op = 1; t.addr = 8'h3C; t.wdata = 32'h0BAD_F00D;
    t.delay = 0; t.rdata = '0; t.drop = 1'b0;
    resp_q.push_back(t);
    @(negedge clk_2);
    req_wr[0] = 1'b1;
    req_addr[0 +: AW] = t.addr;
    req_writedata[0 +: 32] = t.wdata;
    while (!sdio_wr && w < 20) begin
      @(negedge clk_2);
      w++;
    end
    checkOutput("rst_test_strobe_up", 32'(sdio_wr), 32'd1);
    repeat (10) @(negedge clk_2);
    skip_len = sdio_wr;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_wr", 32'(sdio_wr), 32'd0);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_ack", 32'(req_ack), 32'd0);
    req_rd = '0;
    req_wr = '0;
    resp_q.delete();
    repeat (3) @(negedge clk_2);
    rst_n = 1'b1;
    model_last = NREQ - 1;
    repeat (2) @(negedge clk_2);
  endtask

  // SDIO master model: answers each strobe after its delay and checks command, stability, length and gap.
  initial begin
    tx_t cur;
    bit  active = 1'b0;
    bit  bogus = 1'b0;
    bit  seen = 1'b0;
    bit  bad = 1'b0;
    int  hi = 0;
    int  low_cnt = 0;
    forever begin
      @(negedge clk_2);
      if (!active && (sdio_rd || sdio_wr)) begin
        if (resp_q.size() == 0) begin
          failNow("unexpected_strobe");
          bogus = 1'b1;
          cur.delay = 0;
        end else begin
          cur = resp_q.pop_front();
          checkOutput("strobe_wr", 32'(sdio_wr), 32'(cur.op != 0));
          checkOutput("strobe_rd", 32'(sdio_rd), 32'(cur.op == 0));
          checkOutput("strobe_addr", 32'(sdio_addr), 32'(cur.addr));
          checkOutput("strobe_wdata", sdio_writedata, cur.wdata);
          checkOutput("busy_in_issue", 32'(busy), 32'd1);
          if (seen) checkOutput("gap_low_cycles", 32'(low_cnt >= GAP_CYC + 1), 32'd1);
        end
        active = 1'b1;
        hi = 0;
        bad = 1'b0;
      end
      if (active) begin
        if (sdio_rd || sdio_wr) begin
          hi++;
          if (sdio_addr !== cur.addr || sdio_writedata !== cur.wdata || sdio_wr !== (cur.op != 0)) bad = 1'b1;
          if (cur.delay != 0 && hi == cur.delay) begin
            sdio_ready = 1'b1;
            sdio_readdata = cur.rdata;
          end
        end else begin
          active = 1'b0;
          sdio_ready = 1'b0;
          sdio_readdata = $urandom;
          if (skip_len || bogus) begin
            skip_len = 1'b0;
            bogus = 1'b0;
            seen = 1'b0;
          end else begin
            checkOutput("strobe_len", 32'(hi), 32'(exp_len(cur.delay)));
            checkOutput("strobe_stable", 32'(bad), 32'd0);
            seen = 1'b1;
          end
          low_cnt = 1;
        end
      end else begin
        low_cnt++;
      end
    end
  end

  // Ack monitor: pops the scoreboard whenever any ack bit is presented.
  initial begin
    logic [NREQ-1:0] prev = '0;
    exp_t            e;
    int              idx;
    forever begin
      @(negedge clk_2);
      if (req_ack !== '0) begin
        checkOutput("ack_onehot", 32'($onehot(req_ack)), 32'd1);
        checkOutput("ack_pulse", 32'(prev), 32'd0);
        idx = 0;
        for (int i = 0; i < NREQ; i++) if (req_ack[i]) idx = i;
        if (exp_q.size() == 0) begin
          failNow("unexpected_ack");
        end else begin
          e = exp_q.pop_front();
          checkOutput("ack_port", 32'(idx), 32'(e.port));
          checkOutput("ack_readdata", req_readdata, e.rdata);
          checkOutput("ack_err", 32'(req_err), 32'(e.err));
        end
      end
      prev = req_ack;
    end
  end

  initial begin
    logic [NREQ-1:0] mask;
    int              cnt;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk_2);
    checkOutput("rst_ack", 32'(req_ack), 32'd0);
    checkOutput("rst_readdata", req_readdata, 32'd0);
    checkOutput("rst_err", 32'(req_err), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_sdio_rd", 32'(sdio_rd), 32'd0);
    checkOutput("rst_sdio_wr", 32'(sdio_wr), 32'd0);
    checkOutput("rst_sdio_addr", 32'(sdio_addr), 32'd0);
    checkOutput("rst_sdio_wdata", sdio_writedata, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_2);

    addTx(0, 1, 8'h12, 32'hA5A5_0001, 450, $urandom, 1'b0);
    applyStimulus();
    addTx(1, 0, AW'($urandom), $urandom, 5, 32'h1234_5678, 1'b0);
    applyStimulus();

    for (int k = 0; k < 2; k++) begin
      addTx(0, 1, AW'($urandom), $urandom, 3, $urandom, 1'b0);
      addTx(1, 0, AW'($urandom), $urandom, 4, $urandom, 1'b0);
    end
    applyStimulus();

    addTx(0, 1, AW'($urandom), $urandom, SLOW_CYC, $urandom, 1'b0);
    addTx(0, 0, AW'($urandom), $urandom, SLOW_CYC + 1, $urandom, 1'b0);
    addTx(1, 0, AW'($urandom), $urandom, 2100, $urandom, 1'b0);
    applyStimulus();

    addTx(1, 0, AW'($urandom), $urandom, 0, $urandom, 1'b0);
    applyStimulus();

    addTx(0, 2, 8'h5A, 32'hC0DE_0002, 30, $urandom, 1'b1);
    applyStimulus();

    resetMidIssue();
    addTx(1, 0, AW'($urandom), $urandom, 6, $urandom, 1'b0);
    addTx(0, 1, AW'($urandom), $urandom, 7, $urandom, 1'b0);
    applyStimulus();

    for (int r = 0; r < 12; r++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        if (mask[i]) begin
          cnt = $urandom_range(1, 2);
          for (int n = 0; n < cnt; n++)
            addTx(i, $urandom_range(0, 2), AW'($urandom), $urandom, $urandom_range(1, 12), $urandom, 1'b0);
        end
      end
      applyStimulus();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
